// File: rtl/eth_pkg.sv
// Shared Ethernet datapath types and constants.
// Holds the TX arbiter state encoding, the abort pad byte and the watchdog counter sizing.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  localparam logic [7:0] ETH_PAD = 8'h00;

  // A disabled watchdog (timeout 0) still gets a 1-bit counter so no zero-width vector appears.
  function automatic int ctr_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_select.sv
// Combinational round-robin pick: the first set request bit at or above base, wrapping modulo NUM_SRC.
// The module has no state, so it can be reused by the RX-side demux.
module rr_select #(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   base,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] b, input int off);
    int sum;
    sum = int'(b) + off;
    return IDX_W'((sum >= NUM_SRC) ? sum - NUM_SRC : sum);
  endfunction

  // The scan runs from the farthest offset down to the nearest, so the request closest to base wins.
  always_comb begin
    found = 1'b0;
    idx   = base;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      found = found | req[wrap_add(base, i)];
      idx   = req[wrap_add(base, i)] ? wrap_add(base, i) : idx;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the TX MAC from NUM_SRC AXI-Stream sources.
// A stall watchdog ends a stalled frame with an errored pad beat and then discards the rest of that frame.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 2,
  parameter int TIMEOUT    = 16,
  parameter int IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  input  logic [NUM_SRC-1:0]            s_axis_tuser,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          abort_event
);

  localparam int               CTR_W       = ctr_width(TIMEOUT);
  localparam logic [CTR_W-1:0] STALL_LIMIT = CTR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};

  arb_state_t              state_r;
  arb_state_t              state_next_s;
  logic [IDX_W-1:0]        grant_idx_r;
  logic [IDX_W-1:0]        rr_ptr_r;
  logic [IDX_W-1:0]        sel_idx_s;
  logic [IDX_W-1:0]        ptr_next_s;
  logic                    sel_found_s;
  logic                    grant_valid_r;
  logic                    abort_event_r;
  logic                    frame_end_s;
  logic [CTR_W-1:0]        stall_ctr_r;
  logic [DATA_WIDTH-1:0]   src_data_s;
  logic                    src_valid_s;
  logic                    src_last_s;
  logic                    src_user_s;

  rr_select #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req   (s_axis_tvalid),
    .base  (rr_ptr_r),
    .found (sel_found_s),
    .idx   (sel_idx_s)
  );

  assign src_data_s  = s_axis_tdata[grant_idx_r*DATA_WIDTH +: DATA_WIDTH];
  assign src_valid_s = s_axis_tvalid[grant_idx_r];
  assign src_last_s  = s_axis_tlast[grant_idx_r];
  assign src_user_s  = s_axis_tuser[grant_idx_r];
  assign ptr_next_s  = (grant_idx_r == IDX_W'(NUM_SRC - 1)) ? IDX_W'(0) : grant_idx_r + IDX_W'(1);

  assign grant_valid = grant_valid_r;
  assign grant_idx   = grant_idx_r;
  assign abort_event = abort_event_r;

  // Next-state decode and output muxing for the grant/abort/drain sequence.
  always_comb begin
    state_next_s  = state_r;
    frame_end_s   = 1'b0;
    s_axis_tready = {NUM_SRC{1'b0}};
    m_axis_tdata  = {DATA_WIDTH{1'b0}};
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state_r)
      IDLE: begin
        state_next_s = sel_found_s ? ACTIVE : IDLE;
      end
      ACTIVE: begin
        m_axis_tdata               = src_data_s;
        m_axis_tvalid              = src_valid_s;
        m_axis_tlast               = src_last_s;
        m_axis_tuser               = src_user_s;
        s_axis_tready[grant_idx_r] = m_axis_tready;
        if (src_valid_s && m_axis_tready && src_last_s) begin
          frame_end_s  = 1'b1;
          state_next_s = IDLE;
        end else if ((TIMEOUT > 0) && !src_valid_s && (stall_ctr_r == STALL_LIMIT)) begin
          state_next_s = ABORT;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      ABORT: begin
        m_axis_tdata  = DATA_WIDTH'(ETH_PAD);
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        state_next_s  = m_axis_tready ? DRAIN : ABORT;
      end
      DRAIN: begin
        s_axis_tready[grant_idx_r] = 1'b1;
        if (src_valid_s && src_last_s) begin
          frame_end_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      grant_idx_r   <= IDX_W'(0);
      rr_ptr_r      <= IDX_W'(0);
      grant_valid_r <= 1'b0;
      abort_event_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      grant_valid_r <= (state_next_s != IDLE);
      abort_event_r <= (state_r == ABORT) && m_axis_tready;
      if ((state_r == IDLE) && sel_found_s) begin
        grant_idx_r <= sel_idx_s;
      end
      if (frame_end_s) begin
        rr_ptr_r <= ptr_next_s;
      end
    end
  end

  // Watchdog: counts only source starvation; MAC backpressure holds the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_ctr_r <= {CTR_W{1'b0}};
    end else if ((state_r != ACTIVE) || (src_valid_s && m_axis_tready)) begin
      stall_ctr_r <= {CTR_W{1'b0}};
    end else if (!src_valid_s && (stall_ctr_r != CTR_MAX)) begin
      stall_ctr_r <= stall_ctr_r + CTR_W'(1);
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: cycle-accurate vector table plus hand sequences for
// backpressure, watchdog abort and mid-frame reset.
module tb_eth_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [15:0] s_tdata;
  logic [1:0]  s_tvalid, s_tlast, s_tuser, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic        gv, gi, ab;

  int passed = 0;
  int total  = 0;
  int abort_cnt = 0;

  eth_tx_arbiter #(.DATA_WIDTH(8), .NUM_SRC(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .grant_valid(gv), .grant_idx(gi), .abort_event(ab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ab) abort_cnt++;

  typedef struct {
    logic       rst;
    logic [1:0] v, l, u;
    logic [7:0] d0, d1;
    logic       mr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] e(input logic mv, input logic [7:0] md, input logic ml,
                                    input logic mu, input logic [1:0] sr, input logic gvv,
                                    input logic giv, input logic abv);
    return {mv, md, ml, mu, sr, gvv, giv, abv};
  endfunction

  task automatic push_vec(input logic rst, input logic [1:0] v, input logic [1:0] l,
                          input logic [1:0] u, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [15:0] ex);
    vec_t x;
    x.rst = rst; x.v = v; x.l = l; x.u = u; x.d0 = d0; x.d1 = d1; x.mr = 1'b1; x.exp = ex;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [15:0] obs();
    return {m_tvalid, m_tdata, m_tlast, m_tuser, s_tready, gv, gi, ab};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_tvalid = 2'b00; s_tlast = 2'b00; s_tuser = 2'b00; s_tdata = 16'h0000; m_tready = 1'b1;
  endtask

  logic [7:0] cbytes [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
  logic [7:0] dbytes [5] = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
  logic [7:0] got[$];
  logic [9:0] beats[$];
  int k, gap, mirror_bad, ab0, abort_at;
  logic user_seen;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) next_cycle();

    // Frame A1..A4 from src0, single-beat errored frame, then both sources alternating from reset.
    push_vec(1'b1, 2'b01, 2'b00, 2'b00, 8'hA1, 8'h00, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    push_vec(1'b1, 2'b01, 2'b00, 2'b00, 8'hA1, 8'h00, e(1'b1, 8'hA1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b1, 2'b01, 2'b00, 2'b00, 8'hA2, 8'h00, e(1'b1, 8'hA2, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b1, 2'b01, 2'b00, 2'b00, 8'hA3, 8'h00, e(1'b1, 8'hA3, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b1, 2'b01, 2'b01, 2'b00, 8'hA4, 8'h00, e(1'b1, 8'hA4, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    push_vec(1'b1, 2'b01, 2'b01, 2'b01, 8'h55, 8'h00, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    push_vec(1'b1, 2'b01, 2'b01, 2'b01, 8'h55, 8'h00, e(1'b1, 8'h55, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    push_vec(1'b1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    push_vec(1'b1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, e(1'b1, 8'h10, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b1, 2'b11, 2'b00, 2'b00, 8'h11, 8'h20, e(1'b1, 8'h11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b1, 2'b11, 2'b01, 2'b00, 8'h12, 8'h20, e(1'b1, 8'h12, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b1, 2'b11, 2'b00, 2'b00, 8'h13, 8'h20, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
    push_vec(1'b1, 2'b11, 2'b00, 2'b00, 8'h13, 8'h20, e(1'b1, 8'h20, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
    push_vec(1'b1, 2'b11, 2'b00, 2'b00, 8'h13, 8'h21, e(1'b1, 8'h21, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
    push_vec(1'b1, 2'b11, 2'b10, 2'b00, 8'h13, 8'h22, e(1'b1, 8'h22, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
    push_vec(1'b1, 2'b11, 2'b00, 2'b00, 8'h13, 8'h23, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
    push_vec(1'b1, 2'b11, 2'b00, 2'b00, 8'h13, 8'h23, e(1'b1, 8'h13, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
    push_vec(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, e(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset_n = vecs[i].rst; s_tvalid = vecs[i].v; s_tlast = vecs[i].l; s_tuser = vecs[i].u;
      s_tdata = {vecs[i].d1, vecs[i].d0}; m_tready = vecs[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d", i), {16'h0000, obs()}, {16'h0000, vecs[i].exp});
      next_cycle();
    end

    // MAC ready toggling 1010 on a src0 frame: all bytes once, in order, ready mirrored.
    k = 0; mirror_bad = 0; ab0 = abort_cnt; user_seen = 1'b0; got.delete();
    for (int t = 0; t < 40 && k < 4; t++) begin
      s_tvalid = 2'b01; s_tdata = {8'h00, cbytes[k]}; s_tlast = {1'b0, (k == 3)}; s_tuser = 2'b00;
      m_tready = ((t % 2) == 0);
      @(negedge clk);
      if (m_tvalid && m_tready) begin got.push_back(m_tdata); user_seen = user_seen | m_tuser; end
      if (gv && (s_tready[0] !== m_tready)) mirror_bad++;
      if (s_tready[0] && s_tvalid[0]) k++;
      next_cycle();
    end
    idle_inputs();
    check("tog_beats", got.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("tog_byte%0d", i), (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, cbytes[i]});
    check("tog_ready_mirror", mirror_bad, 0);
    check("tog_no_abort", {31'h0, user_seen} + (abort_cnt - ab0), 0);

    // Watchdog: src1 sends 2 bytes, starves 20 cycles, then 3 more bytes ending with tlast.
    k = 0; gap = 0; abort_at = -1; ab0 = abort_cnt; beats.delete();
    for (int t = 0; t < 80 && k < 5; t++) begin
      s_tvalid[0] = 1'b0;
      s_tvalid[1] = (k < 2) || ((k < 5) && (gap >= 20));
      s_tdata = {s_tvalid[1] ? dbytes[k] : 8'h00, 8'h00};
      s_tlast = {(k == 4) && s_tvalid[1], 1'b0};
      s_tuser = 2'b00; m_tready = 1'b1;
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        beats.push_back({m_tdata, m_tlast, m_tuser});
        if (m_tlast && m_tuser) abort_at = gap;
      end
      if ((k == 2) && !s_tvalid[1]) gap++;
      if (s_tready[1] && s_tvalid[1]) k++;
      next_cycle();
    end
    idle_inputs();
    check("wd_src_consumed", k, 5);
    check("wd_beats", beats.size(), 3);
    check("wd_beat0", (beats.size() > 0) ? {22'h0, beats[0]} : 32'hDEAD, {22'h0, 8'hD1, 2'b00});
    check("wd_beat1", (beats.size() > 1) ? {22'h0, beats[1]} : 32'hDEAD, {22'h0, 8'hD2, 2'b00});
    check("wd_abort_beat", (beats.size() > 2) ? {22'h0, beats[2]} : 32'hDEAD, {22'h0, 8'h00, 2'b11});
    check("wd_abort_stall_cycle", abort_at, 16);
    check("wd_abort_pulses", abort_cnt - ab0, 1);

    // Next grant after the aborted src1 frame goes to src0.
    s_tvalid = 2'b11; s_tdata = {8'hF0, 8'hE0}; s_tlast = 2'b01;
    @(negedge clk);
    check("post_abort_idle", {31'h0, m_tvalid}, 0);
    next_cycle();
    @(negedge clk);
    check("post_abort_grant", {22'h0, gv, gi, m_tdata}, {22'h0, 1'b1, 1'b0, 8'hE0});
    next_cycle();

    // Reset on the 3rd byte of a src1 frame, released 2 cycles later with both requesting.
    s_tvalid = 2'b10; s_tdata = {8'h31, 8'h00}; s_tlast = 2'b00;
    next_cycle();
    next_cycle();
    s_tdata = {8'h32, 8'h00};
    next_cycle();
    s_tdata = {8'h33, 8'h40}; s_tvalid = 2'b11; reset_n = 1'b0;
    @(negedge clk);
    check("rst_pre_grant", {30'h0, gv, gi}, {30'h0, 1'b1, 1'b1});
    next_cycle();
    @(negedge clk);
    check("rst_outputs_zero", {16'h0, obs()}, 32'h0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_idle", {16'h0, obs()}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("rst_first_grant", {22'h0, gv, gi, m_tdata}, {22'h0, 1'b1, 1'b0, 8'h40});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single AXI-Stream input of the Ethernet TX MAC between NUM_SRC upstream packet sources, e.g. the UDP/IP encapsulator and the ARP responder.
- A grant is locked for a whole frame, so the MAC never sees interleaved bytes.
- A stall watchdog force-terminates a frame whose source stops supplying data mid-packet, so the MAC does not underrun indefinitely.

Parameters:
- DATA_WIDTH, 8, byte lane width of every stream.
- NUM_SRC, 2, number of requesting sources; legal range 2..8.
- TIMEOUT, 16, cycles of granted-source tvalid low mid-packet before abort; 0 disables the watchdog.
- IDX_W, $clog2(NUM_SRC), width of the grant index; derived, not overridden.

Ports:
- clk  in  1  system clock (125 MHz)
- reset_n  in  1  synchronous, active-low reset
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tlast  in  NUM_SRC  per-source last beat of frame
- s_axis_tuser  in  NUM_SRC  per-source error flag, passed through
- s_axis_tready  out  NUM_SRC  per-source ready
- m_axis_tdata  out  DATA_WIDTH  data to the MAC
- m_axis_tvalid  out  1  valid to the MAC
- m_axis_tlast  out  1  last to the MAC
- m_axis_tuser  out  1  error to the MAC; 1 marks a bad or aborted frame
- m_axis_tready  in  1  ready from the MAC
- grant_valid  out  1  a source currently owns the MAC
- grant_idx  out  IDX_W  index of the owning source
- abort_event  out  1  single-cycle pulse when a watchdog abort beat is accepted

Behaviour:
- Handshake: a beat transfers when tvalid && tready are both high on a rising edge. Sources must hold tdata, tlast and tuser stable while tvalid is high and tready is low.
- States:
  - IDLE: no grant. All s_axis_tready = 0, m_axis_tvalid = 0. If any s_axis_tvalid bit is high, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_SRC. Register it into grant_idx, set grant_valid, go to ACTIVE. Arbitration latency is 1 cycle from tvalid to grant.
  - ACTIVE: combinational pass-through:
    - m_axis_tdata/tvalid/tlast/tuser = source[grant_idx];
    - s_axis_tready[grant_idx] = m_axis_tready; all other ready bits 0.
    - On a handshake with tlast=1: rr_ptr <= (grant_idx+1) mod NUM_SRC, clear grant_valid, go to IDLE. This leaves one dead cycle between frames, which is absorbed by the MAC IFG.
  - ABORT: drive m_axis_tvalid=1, m_axis_tdata=0, m_axis_tlast=1, m_axis_tuser=1. All s_axis_tready = 0. When m_axis_tready is high, pulse abort_event and go to DRAIN.
  - DRAIN: m_axis_tvalid=0, s_axis_tready[grant_idx]=1, beats are discarded. On a source beat with tlast=1: advance rr_ptr as in ACTIVE, go to IDLE.
- Watchdog:
  - stall_ctr is cleared on every ACTIVE source handshake and on entry to ACTIVE.
  - It increments each ACTIVE cycle in which s_axis_tvalid[grant_idx]=0.
  - When stall_ctr reaches TIMEOUT-1 and tvalid is still low, the next state is ABORT.
  - MAC backpressure (tvalid high, tready low) never counts.
  - The counter saturates and is sized $clog2(TIMEOUT+1).
- Boundary rules:
  - A new request during ACTIVE/ABORT/DRAIN waits. No preemption.
  - When all sources request simultaneously, the winner is rr_ptr itself if it requests.
  - If the granted source drops tvalid during the same cycle the watchdog expires, ABORT wins. A beat presented the cycle after is handled in DRAIN.
  - A single-beat frame (tlast on first beat) is legal: IDLE→ACTIVE→IDLE.
  - A tlast beat with tuser=1 from a source is forwarded unchanged. It is not an abort and does not pulse abort_event.
- Reset values:
  - state IDLE, rr_ptr 0, grant_idx 0, grant_valid 0, stall_ctr 0, abort_event 0.
  - All s_axis_tready 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tuser 0, m_axis_tdata 0.
  - Reset mid-frame: outputs return to these values on the next edge. The truncated frame is the MAC's concern. Arbitration restarts at source 0.

Decomposition:
- eth_pkg gains:
  - an arb_state_t enum {IDLE, ACTIVE, ABORT, DRAIN};
  - ETH_PAD (8'h00), used as the abort beat data.
- Sub-module rr_select (combinational priority search from a base pointer, with parameters NUM_SRC and IDX_W). It is reusable by the future RX-side demux.
- All state, counters and muxing live in eth_tx_arbiter.

Test Plan:
- Src0 sends 4-byte frame A1..A4, MAC ready always → m_axis carries A1..A4 with tlast on A4; grant_idx=0; grant_valid low 1 cycle after.
- Src0 and src1 both send 3-byte frames continuously from reset → grants alternate 0,1,0,1; no interleaving; exactly one idle cycle between frames.
- Single frame, m_axis_tready toggling 1010… → every byte delivered exactly once in order; s_axis_tready[0] mirrors m_axis_tready; stall_ctr never expires.
- TIMEOUT=16, src1 sends 2 bytes then holds tvalid low 20 cycles, then 3 more bytes with tlast → abort beat (data 0x00, tlast=1, tuser=1) accepted at stall cycle 16, abort_event pulses once, trailing 3 bytes consumed silently, next grant goes to src0.
- Reset asserted on the 3rd byte of a src1 frame, deasserted 2 cycles later while both sources request → all outputs 0 during reset; first grant afterwards is src0.
- Src0 sends a 1-byte frame with tlast=1, tuser=1 → forwarded with m_axis_tuser=1; abort_event stays 0.
